router_input_port: RTL and testbench

- Router-side receiving end of the NIC→router flit link.
- Accepts flits from NIC out_link_o/is_valid_o and sorts them into per-VC FIFOs.
- Presents buffered flits to the router crossbar.
- Returns per-VC credit_signal and free_signal pulses to the NIC's credit_signal_i/free_signal_i inputs.

---
 rtl/router_input_port.sv | 201 ++++++++++++++++++++
 tb/tb_router_input_port.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_input_port.sv
`default_nettype none
// ============================================================================
//  Module   : router_input_port
//  Purpose  : Router-side receiver of the NIC->router flit link. Incoming
//             flits are sorted into per-VC FIFOs, the FIFO head flits are
//             presented to the crossbar, and per-VC credit/free pulses are
//             returned to the NIC.
//  Ports    :
//    clk              in   clock, rising edge
//    rst              in   asynchronous reset, active low
//    in_link_i        in   flit from NIC, [1:0] = type (00 H, 01 B, 10 T, 11 HT)
//    is_valid_i       in   in_link_i valid this cycle
//    credit_signal_o  out  per-VC pulse: one buffer slot freed
//    free_signal_o    out  per-VC pulse: tail/head-tail drained, VC free
//    vc_flit_o        out  FIFO head flit of every VC (VC v at [v*FW +: FW])
//    vc_valid_o       out  per-VC FIFO non-empty
//    vc_pop_i         in   per-VC crossbar consumes the head flit
//    error_o          out  pulse: a flit was dropped on the previous edge
//  Revision : 1.0 - initial release
// ============================================================================
module router_input_port #(
    parameter int FLIT_WIDTH   = 16,
    parameter int N_TOT_OF_VC  = 4,
    parameter int BUFFER_DEPTH = 4,
    parameter int VC_ID_LSB    = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [FLIT_WIDTH-1:0]             in_link_i,
    input  logic                              is_valid_i,
    output logic [N_TOT_OF_VC-1:0]            credit_signal_o,
    output logic [N_TOT_OF_VC-1:0]            free_signal_o,
    output logic [N_TOT_OF_VC*FLIT_WIDTH-1:0] vc_flit_o,
    output logic [N_TOT_OF_VC-1:0]            vc_valid_o,
    input  logic [N_TOT_OF_VC-1:0]            vc_pop_i,
    output logic                              error_o
);

    localparam int C_VC_W  = $clog2(N_TOT_OF_VC);
    localparam int C_PTR_W = $clog2(BUFFER_DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;

    localparam logic [1:0] C_TYPE_HEAD = 2'b00;
    localparam logic [1:0] C_TYPE_BODY = 2'b01;
    localparam logic [1:0] C_TYPE_TAIL = 2'b10;
    localparam logic [1:0] C_TYPE_HT   = 2'b11;

    localparam logic [C_CNT_W-1:0] C_FULL    = C_CNT_W'(BUFFER_DEPTH);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);
    localparam logic [C_PTR_W-1:0] C_PTR_ONE = C_PTR_W'(1);

    typedef enum logic {
        VC_IDLE = 1'b0,
        VC_OPEN = 1'b1
    } vc_state_t;

    vc_state_t             r_state     [N_TOT_OF_VC];
    vc_state_t             w_state_nxt [N_TOT_OF_VC];
    logic [C_VC_W-1:0]     r_cur_vc;
    logic [C_VC_W-1:0]     w_cur_vc_nxt;

    logic [1:0]            w_type;
    logic [C_VC_W-1:0]     w_head_vc;

    logic [N_TOT_OF_VC-1:0] w_push;
    logic [N_TOT_OF_VC-1:0] w_pop;
    logic [N_TOT_OF_VC-1:0] w_full;
    logic [N_TOT_OF_VC-1:0] w_pop_last;
    logic                   w_drop;

    logic [N_TOT_OF_VC-1:0] r_credit;
    logic [N_TOT_OF_VC-1:0] r_free;
    logic                   r_error;

    assign w_type    = in_link_i[1:0];
    assign w_head_vc = in_link_i[VC_ID_LSB +: C_VC_W];

    // ------------------------------------------------------------------
    // VC state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < N_TOT_OF_VC; v++) begin
                r_state[v] <= VC_IDLE;
            end
            r_cur_vc <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cur_vc <= w_cur_vc_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Acceptance / next-state logic. A flit is either pushed into exactly
    // one VC FIFO or dropped; a dropped flit changes no state.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cur_vc_nxt = r_cur_vc;
        w_push       = '0;
        w_drop       = 1'b0;
        if (is_valid_i) begin
            case (w_type)
                C_TYPE_HEAD, C_TYPE_HT: begin
                    if ((r_state[w_head_vc] == VC_IDLE) && !w_full[w_head_vc]) begin
                        w_push[w_head_vc] = 1'b1;
                        // A head-tail is a complete packet: the VC never opens.
                        if (w_type == C_TYPE_HEAD) begin
                            w_state_nxt[w_head_vc] = VC_OPEN;
                            w_cur_vc_nxt           = w_head_vc;
                        end
                    end else begin
                        w_drop = 1'b1;
                    end
                end
                C_TYPE_BODY, C_TYPE_TAIL: begin
                    if ((r_state[r_cur_vc] == VC_OPEN) && !w_full[r_cur_vc]) begin
                        w_push[r_cur_vc] = 1'b1;
                        if (w_type == C_TYPE_TAIL) begin
                            w_state_nxt[r_cur_vc] = VC_IDLE;
                        end
                    end else begin
                        w_drop = 1'b1;
                    end
                end
                default: begin
                    w_drop = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Per-VC FIFOs
    // ------------------------------------------------------------------
    for (genvar v = 0; v < N_TOT_OF_VC; v++) begin : g_vc
        logic [FLIT_WIDTH-1:0] r_mem [BUFFER_DEPTH];
        logic [C_PTR_W-1:0]    r_wr_ptr;
        logic [C_PTR_W-1:0]    r_rd_ptr;
        logic [C_CNT_W-1:0]    r_count;

        // A pop of an empty FIFO is ignored and earns no credit.
        assign w_pop[v] = vc_pop_i[v] && (r_count != '0);
        // A pop in the same cycle frees the slot the push needs.
        assign w_full[v] = (r_count == C_FULL) && !w_pop[v];
        // Tail (10) and head-tail (11) both have type bit 1 set.
        assign w_pop_last[v] = r_mem[r_rd_ptr][1];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push[v]) begin
                    r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
                end
                if (w_pop[v]) begin
                    r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
                end
                if (w_push[v] && !w_pop[v]) begin
                    r_count <= r_count + C_CNT_ONE;
                end else if (!w_push[v] && w_pop[v]) begin
                    r_count <= r_count - C_CNT_ONE;
                end
            end
        end

        // Storage needs no reset: it is only observed while non-empty.
        always_ff @(posedge clk) begin
            if (w_push[v]) begin
                r_mem[r_wr_ptr] <= in_link_i;
            end
        end

        assign vc_valid_o[v] = (r_count != '0);
        assign vc_flit_o[v*FLIT_WIDTH +: FLIT_WIDTH] =
            vc_valid_o[v] ? r_mem[r_rd_ptr] : '0;
    end

    // ------------------------------------------------------------------
    // Credit / free / error pulses, one cycle after the causing edge
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_credit <= '0;
            r_free   <= '0;
            r_error  <= 1'b0;
        end else begin
            r_credit <= w_pop;
            r_free   <= w_pop & w_pop_last;
            r_error  <= w_drop;
        end
    end

    assign credit_signal_o = r_credit;
    assign free_signal_o   = r_free;
    assign error_o         = r_error;

endmodule
`default_nettype wire

// File: tb/tb_router_input_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_router_input_port
//  Purpose  : Self-checking bench for router_input_port. A queue-based model
//             of the per-VC buffers is compared with the DUT every cycle;
//             directed scenarios add hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_router_input_port;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_link_i = '0;
    logic        is_valid_i = 1'b0;
    logic [3:0]  credit_signal_o;
    logic [3:0]  free_signal_o;
    logic [63:0] vc_flit_o;
    logic [3:0]  vc_valid_o;
    logic [3:0]  vc_pop_i = '0;
    logic        error_o;

    int checks = 0;
    int errors = 0;

    router_input_port #(
        .FLIT_WIDTH  (16),
        .N_TOT_OF_VC (4),
        .BUFFER_DEPTH(4),
        .VC_ID_LSB   (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_link_i      (in_link_i),
        .is_valid_i     (is_valid_i),
        .credit_signal_o(credit_signal_o),
        .free_signal_o  (free_signal_o),
        .vc_flit_o      (vc_flit_o),
        .vc_valid_o     (vc_valid_o),
        .vc_pop_i       (vc_pop_i),
        .error_o        (error_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: packet-level view with one queue per VC
    // ------------------------------------------------------------------
    logic [15:0] mq [4][$];
    bit          mopen [4];
    int          mcur = 0;
    logic [3:0]  exp_credit = '0;
    logic [3:0]  exp_free   = '0;
    logic        exp_error  = 1'b0;

    task automatic model_step();
        bit          popv [4];
        bit          fullv [4];
        int          dst;
        int          hv;
        logic [1:0]  t;
        logic [15:0] f;
        dst = -1;
        exp_error = 1'b0;
        for (int v = 0; v < 4; v++) begin
            popv[v]  = vc_pop_i[v] && (mq[v].size() > 0);
            fullv[v] = (mq[v].size() == 4) && !popv[v];
        end
        if (is_valid_i) begin
            t  = in_link_i[1:0];
            hv = int'(in_link_i[3:2]);
            if (t == 2'b00 || t == 2'b11) begin
                if (!mopen[hv] && !fullv[hv]) begin
                    dst = hv;
                    if (t == 2'b00) begin
                        mopen[hv] = 1'b1;
                        mcur      = hv;
                    end
                end else begin
                    exp_error = 1'b1;
                end
            end else begin
                if (mopen[mcur] && !fullv[mcur]) begin
                    dst = mcur;
                    if (t == 2'b10) mopen[mcur] = 1'b0;
                end else begin
                    exp_error = 1'b1;
                end
            end
        end
        for (int v = 0; v < 4; v++) begin
            exp_credit[v] = popv[v];
            exp_free[v]   = 1'b0;
            if (popv[v]) begin
                f = mq[v].pop_front();
                exp_free[v] = f[1];
            end
        end
        if (dst >= 0) mq[dst].push_back(in_link_i);
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < 4; v++) begin
                mq[v].delete();
                mopen[v] = 1'b0;
            end
            mcur       = 0;
            exp_credit = '0;
            exp_free   = '0;
            exp_error  = 1'b0;
        end else begin
            model_step();
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle comparison, away from the active edge
    // ------------------------------------------------------------------
    logic [3:0]  ev;
    logic [63:0] ef;

    always @(negedge clk) begin
        ev = '0;
        ef = '0;
        for (int v = 0; v < 4; v++) begin
            if (mq[v].size() > 0) begin
                ev[v]         = 1'b1;
                ef[v*16 +: 16] = mq[v][0];
            end
        end
        chk("cyc_valid",  64'(vc_valid_o),      64'(ev));
        chk("cyc_flit",   vc_flit_o,            ef);
        chk("cyc_credit", 64'(credit_signal_o), 64'(exp_credit));
        chk("cyc_free",   64'(free_signal_o),   64'(exp_free));
        chk("cyc_error",  64'(error_o),         64'(exp_error));
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic cyc(input logic v, input logic [15:0] f, input logic [3:0] pop);
        @(negedge clk);
        is_valid_i = v;
        in_link_i  = f;
        vc_pop_i   = pop;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_valid"},  64'(vc_valid_o),      64'd0);
        chk({nm, "_flit"},   vc_flit_o,            64'd0);
        chk({nm, "_credit"}, 64'(credit_signal_o), 64'd0);
        chk({nm, "_free"},   64'(free_signal_o),   64'd0);
        chk({nm, "_error"},  64'(error_o),         64'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;

        // Body straight after reset: no open VC
        cyc(1'b1, 16'h0001, 4'b0000);
        cyc(1'b0, 16'h0000, 4'b0000);
        chk("body_idle_err",   64'(error_o),    64'd1);
        chk("body_idle_valid", 64'(vc_valid_o), 64'd0);
        cyc(1'b0, 16'h0000, 4'b0000);
        chk("body_idle_err_clr", 64'(error_o), 64'd0);

        // Single-flit packet on VC0
        cyc(1'b1, 16'h6F03, 4'b0000);
        cyc(1'b0, 16'h0000, 4'b0001);
        chk("ht_valid", 64'(vc_valid_o),       64'h1);
        chk("ht_flit",  64'(vc_flit_o[15:0]),  64'h6F03);
        cyc(1'b0, 16'h0000, 4'b0000);
        chk("ht_credit", 64'(credit_signal_o), 64'h1);
        chk("ht_free",   64'(free_signal_o),   64'h1);
        chk("ht_empty",  64'(vc_valid_o),      64'h0);
        cyc(1'b0, 16'h0000, 4'b0000);
        chk("ht_credit_once", 64'(credit_signal_o), 64'h0);
        chk("ht_free_once",   64'(free_signal_o),   64'h0);

        // Long packet on VC1 with a gap between the bodies
        cyc(1'b1, 16'h0004, 4'b0000);
        cyc(1'b1, 16'hBBB1, 4'b0000);
        cyc(1'b0, 16'h0000, 4'b0000);
        cyc(1'b1, 16'hCCC1, 4'b0000);
        cyc(1'b1, 16'hFFF2, 4'b0000);
        cyc(1'b0, 16'h0000, 4'b0010);
        chk("long_valid", 64'(vc_valid_o),       64'h2);
        chk("long_head",  64'(vc_flit_o[31:16]), 64'h0004);
        cyc(1'b0, 16'h0000, 4'b0010);
        chk("long_cr1",   64'(credit_signal_o),  64'h2);
        chk("long_fr1",   64'(free_signal_o),    64'h0);
        chk("long_next",  64'(vc_flit_o[31:16]), 64'hBBB1);
        cyc(1'b0, 16'h0000, 4'b0010);
        cyc(1'b0, 16'h0000, 4'b0010);
        chk("long_tailhd", 64'(vc_flit_o[31:16]), 64'hFFF2);
        cyc(1'b0, 16'h0000, 4'b0000);
        chk("long_cr4",   64'(credit_signal_o),  64'h2);
        chk("long_fr4",   64'(free_signal_o),    64'h2);
        chk("long_empty", 64'(vc_valid_o),       64'h0);

        // Overflow on VC2: the fifth flit is dropped
        cyc(1'b1, 16'h0008, 4'b0000);
        cyc(1'b1, 16'hA001, 4'b0000);
        cyc(1'b1, 16'hA101, 4'b0000);
        cyc(1'b1, 16'hA201, 4'b0000);
        cyc(1'b1, 16'hA302, 4'b0000);
        cyc(1'b0, 16'h0000, 4'b0000);
        chk("ovf_err",   64'(error_o),          64'd1);
        chk("ovf_valid", 64'(vc_valid_o),       64'h4);
        chk("ovf_head",  64'(vc_flit_o[47:32]), 64'h0008);
        cyc(1'b0, 16'h0000, 4'b0000);
        chk("ovf_err_once", 64'(error_o), 64'd0);
        repeat (4) cyc(1'b0, 16'h0000, 4'b0100);
        // VC2 is still open, so a new tail is accepted
        cyc(1'b1, 16'hA402, 4'b0000);
        cyc(1'b0, 16'h0000, 4'b0100);
        chk("ovf_open_err",  64'(error_o),          64'd0);
        chk("ovf_open_flit", 64'(vc_flit_o[47:32]), 64'hA402);
        cyc(1'b0, 16'h0000, 4'b0000);
        chk("ovf_free", 64'(free_signal_o), 64'h4);

        // Head to an already open VC3
        cyc(1'b1, 16'h000C, 4'b0000);
        cyc(1'b1, 16'h000C, 4'b0000);
        cyc(1'b0, 16'h0000, 4'b0000);
        chk("hopen_err",   64'(error_o),    64'd1);
        chk("hopen_valid", 64'(vc_valid_o), 64'h8);
        cyc(1'b1, 16'hD002, 4'b0000);
        cyc(1'b0, 16'h0000, 4'b1000);
        cyc(1'b0, 16'h0000, 4'b1000);
        cyc(1'b0, 16'h0000, 4'b0000);
        chk("hopen_free", 64'(free_signal_o), 64'h8);
        chk("hopen_empty", 64'(vc_valid_o),   64'h0);

        // Full VC0 with simultaneous push and pop
        cyc(1'b1, 16'h0000, 4'b0000);
        cyc(1'b1, 16'h0101, 4'b0000);
        cyc(1'b1, 16'h0201, 4'b0000);
        cyc(1'b1, 16'h0301, 4'b0000);
        cyc(1'b1, 16'h0401, 4'b0001);
        cyc(1'b0, 16'h0000, 4'b0000);
        chk("fpp_credit", 64'(credit_signal_o), 64'h1);
        chk("fpp_err",    64'(error_o),         64'd0);
        chk("fpp_head",   64'(vc_flit_o[15:0]), 64'h0101);
        repeat (3) cyc(1'b0, 16'h0000, 4'b0001);
        cyc(1'b0, 16'h0000, 4'b0001);
        chk("fpp_last", 64'(vc_flit_o[15:0]), 64'h0401);
        cyc(1'b0, 16'h0000, 4'b0000);
        chk("fpp_empty", 64'(vc_valid_o), 64'h0);
        cyc(1'b1, 16'h0502, 4'b0000);
        cyc(1'b0, 16'h0000, 4'b0001);
        cyc(1'b0, 16'h0000, 4'b0000);
        chk("fpp_free", 64'(free_signal_o), 64'h1);

        // Asynchronous reset in the middle of a packet on VC1
        cyc(1'b1, 16'h0004, 4'b0000);
        cyc(1'b1, 16'h0501, 4'b0000);
        cyc(1'b0, 16'h0000, 4'b0000);
        chk("mid_valid", 64'(vc_valid_o), 64'h2);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b1, 16'h0601, 4'b0000);
        cyc(1'b0, 16'h0000, 4'b0000);
        chk("post_rst_err",   64'(error_o),    64'd1);
        chk("post_rst_valid", 64'(vc_valid_o), 64'h0);
        cyc(1'b0, 16'h0000, 4'b0000);
        chk("post_rst_err_clr", 64'(error_o), 64'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
